// File: rtl/tff_updown_counter_pkg.sv
// ----------------------------------------------------------------------------
// tff_updown_counter_pkg
//   Shared definitions for the toggle-flop up/down counter:
//   - default counter width
//   - SATURATE mode encodings (wrap at limits / hold at limits)
//   - per-edge operation select used by the counter's next-state logic
// ----------------------------------------------------------------------------
package tff_updown_counter_pkg;

  // Default counter width when the top-level WIDTH parameter is not overridden.
  localparam int CNT_DEFAULT_WIDTH = 8;

  // SATURATE parameter encodings.
  localparam int SAT_MODE_WRAP = 0;  // roll over to the opposite limit
  localparam int SAT_MODE_HOLD = 1;  // stay at the limit that was reached

  // Operation selected on a clock edge, after priority resolution
  // (reset is handled directly in the flops and never appears here).
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLR   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_COUNT = 2'd3
  } cnt_op_e;

endpackage : tff_updown_counter_pkg

// File: rtl/tff_updown_counter_cell.sv
// ----------------------------------------------------------------------------
// tff_cell
//   One bit of the count register: a T flip-flop with synchronous,
//   active-high reset. The stored bit inverts on a rising clock edge
//   whenever t is 1, and holds otherwise.
//
// Ports
//   clk : clock, all state changes on its rising edge
//   rst : synchronous active-high reset, forces q to 0
//   t   : toggle request for this edge
//   q   : registered bit value
// ----------------------------------------------------------------------------
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  // Toggle decision for the next edge.
  always_comb begin
    q_d = q_q;
    if (t) begin
      q_d = ~q_q;
    end else begin
      q_d = q_q;
    end
  end

  // Bit storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : tff_cell

// File: rtl/tff_updown_counter.sv
// ----------------------------------------------------------------------------
// tff_updown_counter
//   Up/down counter whose count register is built from WIDTH T flip-flop
//   cells. Normal counting uses the classic ripple-toggle rule (bit i toggles
//   when all lower bits are 1 going up, or all 0 going down). Clear, load and
//   the limit behaviour are also expressed as toggle vectors: to move the
//   register to an arbitrary target value, each cell is toggled where the
//   current bit differs from the target bit (t = q ^ target).
//
//   Per-edge priority: rst > clr > load > en; with nothing active q holds.
//   A limit event is en=1 with up=1 at MAX_VAL, or en=1 with up=0 at 0.
//   SATURATE=0 rolls over to the opposite limit, SATURATE=1 holds.
//
// Parameters
//   WIDTH    : counter bit width (1..32)
//   MAX_VAL  : upper count limit (1..2**WIDTH-1), defaults to all ones
//   SATURATE : SAT_MODE_WRAP or SAT_MODE_HOLD
//
// Ports
//   clk      : clock, rising-edge active
//   rst      : synchronous active-high reset (q=0, wrap=0, ovf=0)
//   clr      : synchronous clear of count and sticky ovf
//   load     : load min(load_val, MAX_VAL) into the count
//   load_val : value to load
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   q        : registered count
//   wrap     : registered one-cycle pulse following each limit event
//   ovf      : sticky limit-event flag, cleared by clr or rst
// ----------------------------------------------------------------------------
module tff_updown_counter
  import tff_updown_counter_pkg::*;
#(
  parameter int               WIDTH    = CNT_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = SAT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             ovf
);

  localparam bit SAT_HOLD_EN = (SATURATE == SAT_MODE_HOLD);

  // Clamp a load value so the register can never be placed above MAX_VAL.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > MAX_VAL) begin
      r = MAX_VAL;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] count_s;     // current register value from the cells
  logic [WIDTH-1:0] chain_t_s;   // plain ripple-toggle vector
  logic [WIDTH-1:0] t_s;         // final toggle vector applied to the cells
  logic             up_limit_s;
  logic             dn_limit_s;
  cnt_op_e          op_s;

  logic             wrap_q;
  logic             wrap_d;
  logic             ovf_q;
  logic             ovf_d;

  // Count register: one T flip-flop per bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_s[gi]),
      .q   (count_s[gi])
    );
  end

  // Ripple-toggle rule: bit i toggles when every lower bit equals the
  // direction's carry value (all ones going up, all zeros going down).
  always_comb begin
    logic all_ones;
    logic all_zeros;
    chain_t_s = '0;
    all_ones  = en;
    all_zeros = en;
    for (int i = 0; i < WIDTH; i++) begin
      if (up) begin
        chain_t_s[i] = all_ones;
      end else begin
        chain_t_s[i] = all_zeros;
      end
      all_ones  = all_ones & count_s[i];
      all_zeros = all_zeros & ~count_s[i];
    end
  end

  // Limit detection. The >= compare is defensive: the register cannot
  // exceed MAX_VAL in normal operation.
  always_comb begin
    up_limit_s = 1'b0;
    dn_limit_s = 1'b0;
    if (up) begin
      up_limit_s = (count_s >= MAX_VAL);
    end else begin
      dn_limit_s = (count_s == {WIDTH{1'b0}});
    end
  end

  // Priority resolution of the synchronous controls.
  always_comb begin
    op_s = OP_HOLD;
    if (clr) begin
      op_s = OP_CLR;
    end else if (load) begin
      op_s = OP_LOAD;
    end else if (en) begin
      op_s = OP_COUNT;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Next-state: toggle vector for the cells plus wrap/ovf next values.
  // Moving to a target value T is done with t = count ^ T.
  always_comb begin
    t_s    = '0;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    case (op_s)
      OP_CLR: begin
        t_s   = count_s;
        ovf_d = 1'b0;
      end
      OP_LOAD: begin
        t_s = count_s ^ clamp_load(load_val);
      end
      OP_COUNT: begin
        if (up_limit_s || dn_limit_s) begin
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
          if (SAT_HOLD_EN) begin
            t_s = '0;
          end else if (up_limit_s) begin
            t_s = count_s;
          end else begin
            t_s = count_s ^ MAX_VAL;
          end
        end else begin
          t_s = chain_t_s;
        end
      end
      OP_HOLD: begin
        t_s = '0;
      end
      default: begin
        t_s = '0;
      end
    endcase
  end

  // Limit-event flags; reset discards any pending wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q    = count_s;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule : tff_updown_counter

// File: tb/tb_tff_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_tff_updown_counter
//   Three 4-bit counter instances:
//     id 0 : MAX_VAL=15, wrapping
//     id 1 : MAX_VAL=9,  saturating
//     id 2 : MAX_VAL=9,  wrapping
//   Each directed vector drives one instance (the others idle) and pushes the
//   hand-computed expected q/wrap/ovf into a queue; a monitor on the falling
//   edge pops and compares.
// ----------------------------------------------------------------------------
module tb_tff_updown_counter;

  typedef struct {
    int         id;
    logic [3:0] q;
    logic       wrap;
    logic       ovf;
    string      name;
  } exp_t;

  logic       clk;
  logic [2:0] rst_v, clr_v, load_v, en_v, up_v;
  logic [3:0] lv_v [3];
  logic [3:0] q_a, q_b, q_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       ovf_a, ovf_b, ovf_c;

  exp_t exp_q [$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  tff_updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(0)) u_dut_a (
    .clk(clk), .rst(rst_v[0]), .clr(clr_v[0]), .load(load_v[0]), .load_val(lv_v[0]),
    .en(en_v[0]), .up(up_v[0]), .q(q_a), .wrap(wrap_a), .ovf(ovf_a));

  tff_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) u_dut_b (
    .clk(clk), .rst(rst_v[1]), .clr(clr_v[1]), .load(load_v[1]), .load_val(lv_v[1]),
    .en(en_v[1]), .up(up_v[1]), .q(q_b), .wrap(wrap_b), .ovf(ovf_b));

  tff_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) u_dut_c (
    .clk(clk), .rst(rst_v[2]), .clr(clr_v[2]), .load(load_v[2]), .load_val(lv_v[2]),
    .en(en_v[2]), .up(up_v[2]), .q(q_c), .wrap(wrap_c), .ovf(ovf_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: everything queued before this falling edge is due now.
  exp_t       m_e;
  logic [3:0] m_q;
  logic       m_w, m_o;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      case (m_e.id)
        0:       begin m_q = q_a; m_w = wrap_a; m_o = ovf_a; end
        1:       begin m_q = q_b; m_w = wrap_b; m_o = ovf_b; end
        default: begin m_q = q_c; m_w = wrap_c; m_o = ovf_c; end
      endcase
      vec_cnt++;
      if (m_q !== m_e.q || m_w !== m_e.wrap || m_o !== m_e.ovf) begin
        miss_cnt++;
        $display("FAIL %s (dut %0d): got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                 m_e.name, m_e.id, m_q, m_w, m_o, m_e.q, m_e.wrap, m_e.ovf);
      end
    end
  end

  task automatic idle_all();
    rst_v  = 3'b000;
    clr_v  = 3'b000;
    load_v = 3'b000;
    en_v   = 3'b000;
    up_v   = 3'b000;
    for (int i = 0; i < 3; i++) lv_v[i] = 4'd0;
  endtask

  task automatic push_exp(input int id, input logic [3:0] eq, input logic ew, input logic eo,
                          input string nm);
    exp_t x;
    x.id   = id;
    x.q    = eq;
    x.wrap = ew;
    x.ovf  = eo;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  // One directed vector on instance id, with its expected post-edge outputs.
  task automatic apply(input int id, input logic r, input logic c, input logic l,
                       input logic [3:0] lv, input logic e, input logic u,
                       input logic [3:0] eq, input logic ew, input logic eo, input string nm);
    @(negedge clk);
    idle_all();
    rst_v[id]  = r;
    clr_v[id]  = c;
    load_v[id] = l;
    lv_v[id]   = lv;
    en_v[id]   = e;
    up_v[id]   = u;
    @(posedge clk);
    push_exp(id, eq, ew, eo, nm);
  endtask

  initial begin
    idle_all();
    // Reset all instances together.
    @(negedge clk);
    rst_v = 3'b111;
    @(posedge clk);
    for (int i = 0; i < 3; i++) push_exp(i, 4'd0, 1'b0, 1'b0, "reset");

    //            id r     c     l     lv     e     u     q      w     o
    // Wrap boundary, MAX_VAL=15
    apply(0, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 4'd14, 1'b0, 1'b0, "a_load14");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd15, 1'b0, 1'b0, "a_up_to15");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1, "a_wrap_up");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  1'b0, 1'b1, "a_after_wrap");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd1,  1'b0, 1'b1, "a_hold");
    // Priority
    apply(0, 1'b0, 1'b1, 1'b1, 4'd7,  1'b1, 1'b1, 4'd0,  1'b0, 1'b0, "a_clr_beats_load_en");
    apply(0, 1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 4'd3,  1'b0, 1'b0, "a_load3");
    apply(0, 1'b1, 1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0, "a_rst_beats_load");
    // Direction reversal
    apply(0, 1'b0, 1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 4'd5,  1'b0, 1'b0, "a_load5");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd6,  1'b0, 1'b0, "a_rev_up1");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  1'b0, 1'b0, "a_rev_dn1");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd6,  1'b0, 1'b0, "a_rev_up2");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  1'b0, 1'b0, "a_rev_dn2");
    // Reset right after a limit event
    apply(0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, "a_load15");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1, "a_limit_before_rst");
    apply(0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  1'b0, 1'b0, "a_rst_mid");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0, "a_no_residual");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  1'b0, 1'b0, "a_resume");
    // Down wrap, then clr against a same-edge limit event
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 1'b0, "a_dn_to0");
    apply(0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 1'b1, 1'b1, "a_wrap_dn");
    apply(0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0, "a_clr");
    apply(0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 1'b0, "a_clr_beats_limit");

    // Saturating, MAX_VAL=9: up held for 12 edges from 0
    for (int k = 1; k <= 12; k++) begin
      if (k <= 9) apply(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'(k), 1'b0, 1'b0, "b_sat_count");
      else        apply(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9,  1'b1, 1'b1, "b_sat_hold");
    end
    apply(1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd9,  1'b0, 1'b1, "b_idle");
    apply(1, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b1, "b_load0");
    apply(1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b1, 1'b1, "b_sat_dn");
    apply(1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b1, 1'b1, "b_sat_dn2");
    apply(1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  1'b0, 1'b1, "b_up_from0");
    apply(1, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd9,  1'b0, 1'b1, "b_load15_clamp");

    // Wrapping, MAX_VAL=9: clamped load and both wraps
    apply(2, 1'b0, 1'b0, 1'b1, 4'd13, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0, "c_load13_clamp");
    apply(2, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1, "c_wrap_up");
    apply(2, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b1, "c_load0");
    apply(2, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd9,  1'b1, 1'b1, "c_wrap_dn");
    apply(2, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd8,  1'b0, 1'b1, "c_dn_from9");
    apply(2, 1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 4'd9,  1'b0, 1'b1, "c_load10_clamp");
    apply(2, 1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 4'd3,  1'b0, 1'b1, "c_load3");

    @(negedge clk);
    idle_all();
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miss_cnt++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule : tb_tff_updown_counter
